// File: rtl/sdram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one SDRAM controller command port.
// Commands pass through combinationally; an in-order tag FIFO routes read responses home.
module sdram_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORD_LEN        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_LEN-1:0]   m0_wr,
  input  logic                  m0_rd,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic                  m0_rdy,
  output logic                  m0_rvalid,
  output logic                  m0_error,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  input  logic [WORD_LEN-1:0]   m1_wr,
  input  logic                  m1_rd,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic                  m1_rdy,
  output logic                  m1_rvalid,
  output logic                  m1_error,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic [WORD_LEN-1:0]   s_wr,
  output logic                  s_rd,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_rdy,
  input  logic                  s_rvalid,
  input  logic                  s_error,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  output logic                  tag_err
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  logic                       prio_q;
  logic                       last_id_q;
  logic                       tag_err_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;

  logic rd_only0, rd_only1, req0, req1, elig0, elig1, gnt0, gnt1;
  logic fifo_empty, fifo_full, rd_blocked, accept, push, pop, head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntMax);
  assign head       = tag_q[rd_ptr_q];
  assign pop        = s_rvalid & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a read.
  assign rd_blocked = fifo_full & ~pop;

  assign rd_only0 = m0_rd & ~(|m0_wr);
  assign rd_only1 = m1_rd & ~(|m1_wr);
  assign req0     = (|m0_wr) | m0_rd;
  assign req1     = (|m1_wr) | m1_rd;
  assign elig0    = req0 & ~(rd_only0 & rd_blocked);
  assign elig1    = req1 & ~(rd_only1 & rd_blocked);
  assign gnt0     = elig0 & (~elig1 | ~prio_q);
  assign gnt1     = elig1 & (~elig0 | prio_q);

  assign accept = (gnt0 | gnt1) & s_rdy;
  assign push   = accept & ((gnt0 & rd_only0) | (gnt1 & rd_only1));

  always_comb begin
    s_addr       = m0_addr;
    s_write_data = m0_write_data;
    s_wr         = '0;
    s_rd         = 1'b0;
    if (gnt1) begin
      s_addr       = m1_addr;
      s_write_data = m1_write_data;
    end
    if (rst_n) begin
      if (gnt0) begin
        s_wr = m0_wr;
        s_rd = rd_only0;
      end else if (gnt1) begin
        s_wr = m1_wr;
        s_rd = rd_only1;
      end
    end
  end

  assign m0_rdy = rst_n & gnt0 & s_rdy;
  assign m1_rdy = rst_n & gnt1 & s_rdy;

  assign m0_rvalid = rst_n & pop & ~head;
  assign m1_rvalid = rst_n & pop & head;

  // Errors with a response follow the tag; bare errors go to the last accepted requester.
  always_comb begin
    m0_error = 1'b0;
    m1_error = 1'b0;
    if (rst_n && s_error) begin
      if (s_rvalid) begin
        m0_error = pop & ~head;
        m1_error = pop & head;
      end else begin
        m0_error = ~last_id_q;
        m1_error = last_id_q;
      end
    end
  end

  assign m0_read_data = s_read_data;
  assign m1_read_data = s_read_data;
  assign tag_err      = tag_err_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      last_id_q <= 1'b0;
      tag_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_q     <= '0;
    end else begin
      if (accept) begin
        prio_q    <= gnt0;
        last_id_q <= gnt1;
      end
      if (push) begin
        tag_q[wr_ptr_q] <= gnt1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (s_rvalid && fifo_empty) begin
        tag_err_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule
